qspi_slave: RTL

QSPI_SLAVE -- requirements
Module: qspi_slave

---
 rtl/qspi_slave.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/qspi_slave.sv
// Quad-SPI memory target: mode 0, command 0xEB quad read (6 dummy cycles) and 0x38 quad write, 24-bit address.
// Transfer/error statistics counters are built only when QSPI_SLAVE_STAT_EN is defined.
`timescale 1ns/1ps
module qspi_slave #(
  parameter int MEM_AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        ce_n,
  inout  wire  [3:0]  sio,
  output logic        busy,
  output logic [15:0] xfer_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADR    = 3'd2,
    DUMMY  = 3'd3,
    RDATA  = 3'd4,
    WDATA  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'hEB;
  localparam logic [7:0] CMD_WRITE = 8'h38;
  localparam logic [3:0] DUMMY_CYC = 4'd6;
  localparam int         MEM_DEPTH = 1 << MEM_AW;

  logic              sck_meta_r, sck_sync_r, sck_prev_r;
  logic              ce_meta_r, ce_sync_r, ce_prev_r;
  logic [3:0]        sio_meta_r, sio_sync_r;
  logic              sck_rise_s, sck_fall_s, ce_rise_s, ce_fall_s;

  state_t            state_r, state_nx_s;
  logic [3:0]        cnt_r, cnt_nx_s;
  logic [19:0]       shift_r, shift_nx_s;
  logic              rd_mode_r, rd_mode_nx_s;
  logic [MEM_AW-1:0] addr_r, addr_nx_s;
  logic [3:0]        wr_hi_r, wr_hi_nx_s;
  logic              half_r, half_nx_s;
  logic [3:0]        sio_out_r, sio_out_nx_s;
  logic              sio_oe_r, sio_oe_nx_s;
  logic              busy_r;
  logic              mem_we_s;
  logic [7:0]        mem_wdata_s;
  logic [7:0]        rd_data_r;
  logic              xfer_inc_s, err_inc_s;
  logic [MEM_AW-1:0] addr_inc_s;

  logic [7:0]        mem [MEM_DEPTH];

  // Input synchronizers; left unreset so a reset with ce_n held low cannot fabricate a ce_n falling edge.
  always_ff @(posedge clk) begin
    sck_meta_r <= sck;
    sck_sync_r <= sck_meta_r;
    sck_prev_r <= sck_sync_r;
    ce_meta_r  <= ce_n;
    ce_sync_r  <= ce_meta_r;
    ce_prev_r  <= ce_sync_r;
    sio_meta_r <= sio;
    sio_sync_r <= sio_meta_r;
  end

  assign sck_rise_s = sck_sync_r & ~sck_prev_r;
  assign sck_fall_s = ~sck_sync_r & sck_prev_r;
  assign ce_rise_s  = ce_sync_r & ~ce_prev_r;
  assign ce_fall_s  = ~ce_sync_r & ce_prev_r;
  assign addr_inc_s = addr_r + {{(MEM_AW-1){1'b0}}, 1'b1};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and datapath decode; ce_n rising edge overrides any sck activity.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    shift_nx_s   = shift_r;
    rd_mode_nx_s = rd_mode_r;
    addr_nx_s    = addr_r;
    wr_hi_nx_s   = wr_hi_r;
    half_nx_s    = half_r;
    sio_out_nx_s = sio_out_r;
    sio_oe_nx_s  = sio_oe_r;
    mem_we_s     = 1'b0;
    mem_wdata_s  = {wr_hi_r, sio_sync_r};
    xfer_inc_s   = 1'b0;
    err_inc_s    = 1'b0;
    if (ce_rise_s) begin
      state_nx_s  = IDLE;
      sio_oe_nx_s = 1'b0;
      half_nx_s   = 1'b0;
      cnt_nx_s    = 4'd0;
      xfer_inc_s  = (state_r == RDATA) || (state_r == WDATA);
    end else begin
      case (state_r)
        IDLE: begin
          if (ce_fall_s) begin
            state_nx_s = CMD;
            cnt_nx_s   = 4'd0;
            half_nx_s  = 1'b0;
          end else begin
            state_nx_s = IDLE;
          end
        end
        CMD: begin
          if (sck_rise_s) begin
            shift_nx_s = {shift_r[15:0], sio_sync_r};
            if (cnt_r == 4'd1) begin
              cnt_nx_s = 4'd0;
              if ({shift_r[3:0], sio_sync_r} == CMD_READ) begin
                state_nx_s   = ADR;
                rd_mode_nx_s = 1'b1;
              end else if ({shift_r[3:0], sio_sync_r} == CMD_WRITE) begin
                state_nx_s   = ADR;
                rd_mode_nx_s = 1'b0;
              end else begin
                state_nx_s = IGNORE;
                err_inc_s  = 1'b1;
              end
            end else begin
              cnt_nx_s = cnt_r + 4'd1;
            end
          end else begin
            cnt_nx_s = cnt_r;
          end
        end
        ADR: begin
          if (sck_rise_s) begin
            shift_nx_s = {shift_r[15:0], sio_sync_r};
            if (cnt_r == 4'd5) begin
              // Upper address bits beyond the memory size are dropped here.
              addr_nx_s  = MEM_AW'({shift_r, sio_sync_r});
              cnt_nx_s   = 4'd0;
              half_nx_s  = 1'b0;
              state_nx_s = rd_mode_r ? DUMMY : WDATA;
            end else begin
              cnt_nx_s = cnt_r + 4'd1;
            end
          end else begin
            cnt_nx_s = cnt_r;
          end
        end
        DUMMY: begin
          if (sck_rise_s) begin
            cnt_nx_s = cnt_r + 4'd1;
          end else if (sck_fall_s && (cnt_r == DUMMY_CYC)) begin
            sio_out_nx_s = rd_data_r[7:4];
            sio_oe_nx_s  = 1'b1;
            half_nx_s    = 1'b1;
            state_nx_s   = RDATA;
          end else begin
            cnt_nx_s = cnt_r;
          end
        end
        RDATA: begin
          // rd_data_r tracks mem[addr_r] a clk after addr_r moves, well before the next falling edge.
          if (sck_fall_s) begin
            if (half_r) begin
              sio_out_nx_s = rd_data_r[3:0];
              half_nx_s    = 1'b0;
              addr_nx_s    = addr_inc_s;
            end else begin
              sio_out_nx_s = rd_data_r[7:4];
              half_nx_s    = 1'b1;
            end
          end else begin
            sio_out_nx_s = sio_out_r;
          end
        end
        WDATA: begin
          if (sck_rise_s) begin
            if (half_r) begin
              mem_we_s  = 1'b1;
              half_nx_s = 1'b0;
              addr_nx_s = addr_inc_s;
            end else begin
              wr_hi_nx_s = sio_sync_r;
              half_nx_s  = 1'b1;
            end
          end else begin
            half_nx_s = half_r;
          end
        end
        IGNORE: begin
          state_nx_s = IGNORE;
        end
        default: begin
          state_nx_s  = IDLE;
          sio_oe_nx_s = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= 4'd0;
      shift_r   <= 20'd0;
      rd_mode_r <= 1'b0;
      addr_r    <= {MEM_AW{1'b0}};
      wr_hi_r   <= 4'd0;
      half_r    <= 1'b0;
      sio_out_r <= 4'd0;
      sio_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_nx_s;
      shift_r   <= shift_nx_s;
      rd_mode_r <= rd_mode_nx_s;
      addr_r    <= addr_nx_s;
      wr_hi_r   <= wr_hi_nx_s;
      half_r    <= half_nx_s;
      sio_out_r <= sio_out_nx_s;
      sio_oe_r  <= sio_oe_nx_s;
      busy_r    <= ~ce_sync_r;
    end
  end

  // Memory array, deliberately untouched by rst; read port is registered.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem[addr_r] <= mem_wdata_s;
    end
    rd_data_r <= mem[addr_r];
  end

  assign sio  = sio_oe_r ? sio_out_r : 4'bzzzz;
  assign busy = busy_r;

`ifdef QSPI_SLAVE_STAT_EN
  logic [15:0] xfer_cnt_r, err_cnt_r;

  // Saturating transaction and unknown-command counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_r <= 16'd0;
      err_cnt_r  <= 16'd0;
    end else begin
      if (xfer_inc_s && (xfer_cnt_r != 16'hFFFF)) begin
        xfer_cnt_r <= xfer_cnt_r + 16'd1;
      end
      if (err_inc_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign xfer_cnt = xfer_cnt_r;
  assign err_cnt  = err_cnt_r;
`else
  logic stat_unused_s;
  assign stat_unused_s = xfer_inc_s ^ err_inc_s;
  assign xfer_cnt      = 16'd0;
  assign err_cnt       = 16'd0;
`endif

endmodule
